// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for the CIC decimator: flush, optional warm-up, decimation strobe, output capture.
// Build option: define CIC_DECIM_CTRL_WARMUP_EN to discard the first N_STAGES post-flush strobes.
module cic_decim_ctrl #(
  parameter int RATE_W       = 8,
  parameter int DEFAULT_RATE = 8,
  parameter int DOUT_W       = 16,
  parameter int N_STAGES     = 3,
  parameter int FLUSH_CYC    = 4,
  parameter int DP_LAT       = 1
) (
  input  logic              cic_clk,
  input  logic              cic_rst,
  input  logic              cfg_enable,
  input  logic              cfg_load,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              din_valid,
  output logic              cic_en,
  output logic              cic_dec_stb,
  output logic              cic_clr,
  input  logic [DOUT_W-1:0] cic_dout,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_WARMUP = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] r_phase;
  logic [3:0]        r_flush_cnt;
  logic [DP_LAT-1:0] r_pipe;
  logic [DOUT_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_ovf;
  logic              w_clear;
  logic              w_active;
  logic              w_en;
  logic              w_stb;
  logic              w_cap;
  logic              w_flush_done;
  logic [RATE_W-1:0] w_rate_m1;

  // Disable, or a reload while running, restarts the datapath sequencing from scratch.
  assign w_clear      = ~cfg_enable | (cfg_load & (r_state != S_IDLE));
  assign w_active     = (r_state == S_WARMUP) | (r_state == S_RUN);
  assign w_rate_m1    = r_rate - RATE_W'(1);
  assign w_en         = w_active & din_valid;
  assign w_stb        = w_en & (r_phase == w_rate_m1);
  assign w_cap        = r_pipe[DP_LAT-1];
  assign w_flush_done = (r_flush_cnt == 4'(FLUSH_CYC - 1));
  assign dbg_state    = r_state;

`ifdef CIC_DECIM_CTRL_WARMUP_EN
  localparam int WW = (N_STAGES < 2) ? 1 : $clog2(N_STAGES + 1);
  logic [WW-1:0] r_warm_cnt;

  always_ff @(posedge cic_clk) begin
    if (cic_rst || w_clear || (r_state != S_WARMUP)) r_warm_cnt <= '0;
    else if (w_stb)                                  r_warm_cnt <= r_warm_cnt + WW'(1);
  end
`endif

  always_ff @(posedge cic_clk) begin
    if (cic_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cfg_enable) w_next = S_FLUSH;
      S_FLUSH: begin
`ifdef CIC_DECIM_CTRL_WARMUP_EN
        if (w_flush_done) w_next = S_WARMUP;
`else
        if (w_flush_done) w_next = S_RUN;
`endif
      end
      S_WARMUP: begin
`ifdef CIC_DECIM_CTRL_WARMUP_EN
        if (w_stb && (r_warm_cnt == WW'(N_STAGES - 1))) w_next = S_RUN;
`endif
      end
      default: w_next = r_state;
    endcase
    if (cfg_load && (r_state != S_IDLE)) w_next = S_FLUSH;
    if (!cfg_enable)                     w_next = S_IDLE;
  end

  always_comb begin
    cic_en      = w_en;
    cic_dec_stb = w_stb;
    cic_clr     = (r_state == S_FLUSH);
    busy        = (r_state != S_IDLE);
  end

  always_ff @(posedge cic_clk) begin
    if (cic_rst)       r_rate <= RATE_W'(DEFAULT_RATE);
    else if (cfg_load) r_rate <= (cfg_rate == '0) ? RATE_W'(1) : cfg_rate;
  end

  always_ff @(posedge cic_clk) begin
    if (cic_rst || w_clear || (r_state != S_FLUSH)) r_flush_cnt <= '0;
    else                                            r_flush_cnt <= r_flush_cnt + 4'd1;
  end

  always_ff @(posedge cic_clk) begin
    if (cic_rst || w_clear || !w_active) r_phase <= '0;
    else if (w_en)                       r_phase <= (r_phase == w_rate_m1) ? '0 : r_phase + RATE_W'(1);
  end

  // Only RUN-state strobes enter the pipe, so warm-up strobes never reach the capture register.
  always_ff @(posedge cic_clk) begin
    if (cic_rst || w_clear) r_pipe <= '0;
    else                    r_pipe <= (r_pipe << 1) | DP_LAT'(w_stb & (r_state == S_RUN));
  end

  // dout/dout_valid: a sample transfers on any cycle where dout_valid & dout_ready are both high;
  // dout is stable while dout_valid is high and not yet accepted, and a capture into an unaccepted slot is dropped.
  always_ff @(posedge cic_clk) begin
    if (cic_rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (cfg_load) r_ovf <= 1'b0;
      if (w_clear) begin
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
      end else if (w_cap) begin
        if (r_dout_valid && !dout_ready) begin
          r_ovf <= 1'b1;
        end else begin
          r_dout       <= cic_dout;
          r_dout_valid <= 1'b1;
        end
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign ovf        = r_ovf;

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for the CIC decimator datapath. It runs the integrator and comb stages, generates the decimation strobe at a runtime-programmable rate, and clears the filter whenever it is enabled or its rate changes. It discards settling outputs, then presents decimated samples to the downstream consumer over a valid/ready interface. It sits between the sample source, the CIC datapath and the consumer, in the `cic_clk` domain.

## Interface
- `RATE_W`, 8: width of the decimation-rate field.
- `DEFAULT_RATE`, 8: rate loaded at reset.
- `DOUT_W`, 16: decimated sample width; matches the datapath `cic_dout`.
- `N_STAGES`, 3: number of comb stages; sets the warm-up discard count.
- `FLUSH_CYC`, 4: number of cycles `cic_clr` is held, 1..15.
- `DP_LAT`, 1: datapath latency from `cic_dec_stb` to a valid `cic_dout`, 1..4.

- `cic_clk`  in  1  clock; the only clock.
- `cic_rst`  in  1  synchronous, active-high reset.
- `cfg_enable`  in  1  level; run the filter while high.
- `cfg_load`  in  1  one-cycle pulse; latch `cfg_rate`.
- `cfg_rate`  in  RATE_W  decimation factor R; 0 is treated as 1.
- `din_valid`  in  1  input sample strobe from the source.
- `cic_en`  out  1  integrator advance enable to the datapath.
- `cic_dec_stb`  out  1  comb/decimate strobe to the datapath.
- `cic_clr`  out  1  synchronous clear to all datapath registers.
- `cic_dout`  in  DOUT_W  datapath output.
- `dout`  out  DOUT_W  held decimated sample.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  consumer accepts `dout`.
- `busy`  out  1  controller is in any state other than IDLE.
- `ovf`  out  1  sticky; a decimated sample was dropped.

## Operation
- States: IDLE, FLUSH, WARMUP, RUN.
- IDLE:
  - `cic_en`=`cic_dec_stb`=`cic_clr`=0.
  - If `cfg_enable`=1, go to FLUSH.
- FLUSH:
  - `cic_clr`=1 on every FLUSH cycle; `cic_en`=0.
  - Phase counter is held at 0.
  - After exactly FLUSH_CYC cycles, go to WARMUP.
- WARMUP and RUN:
  - `cic_en` = `din_valid` (combinational).
  - Phase counter increments on each `cic_en` and wraps from R−1 to 0.
  - `cic_dec_stb` = `cic_en` & (phase == R−1), combinational.
  - WARMUP counts N_STAGES strobes, then goes to RUN. Those strobes produce no captures.
- Capture:
  - A DP_LAT-deep pipe carries RUN-state strobes.
  - When the pipe output is 1, `cic_dout` is loaded into `dout` and `dout_valid` is set.
  - If `dout_valid`=1 and `dout_ready`=0 at capture, the new sample is dropped, `dout` is kept and `ovf` is set.
  - Capture with a same-cycle handshake (`dout_valid` & `dout_ready`) is not an overflow; the new sample loads.
- Handshake: `dout_valid` falls the cycle after `dout_valid` & `dout_ready`, unless a capture coincides.
- `cfg_load`:
  - `rate_q` ← max(`cfg_rate`, 1) in any state.
  - Outside IDLE it also forces FLUSH. `dout_valid`, the capture pipe and the phase counter are cleared.
- `cfg_enable`=0 in any state: next state is IDLE, with the same clears. This has priority over the `cfg_load` state change.
- `ovf` is cleared only by reset or by a `cfg_load` pulse.

## Timing
- Reset: state IDLE, `rate_q`=DEFAULT_RATE, and every output is 0.
- `cfg_enable` rises at cycle t: `busy`=1 and `cic_clr`=1 from t+1 through t+FLUSH_CYC.
- Decimated output latency: `dout_valid` rises DP_LAT+1 cycles after the `cic_dec_stb` cycle, since the capture register adds one cycle.
- Throughput: at most one output per R accepted inputs. R=1 yields a strobe on every `din_valid`.
- Wrap: `rate_q`=255 with `RATE_W`=8 is legal; the phase counter is RATE_W bits wide.
- `din_valid` during FLUSH or IDLE is ignored and not counted.

## Configuration
- `CIC_DECIM_CTRL_WARMUP_EN`:
  - Defined: the WARMUP state exists and the first N_STAGES post-flush strobes are discarded.
  - Undefined: FLUSH goes directly to RUN, and the first strobe is captured.
  - All other behaviour is identical in both builds.

## Test plan
- Reset then enable with R=8 and `din_valid` held high: `cic_clr` is high for 4 cycles. With WARMUP_EN, the first `dout_valid` follows the 4th strobe (strobe 32 inputs after flush) at +2 cycles; later outputs follow every 8 inputs.
- `cfg_load` with `cfg_rate`=0 in RUN: FLUSH re-entered and `dout_valid` cleared; after warm-up a strobe occurs on every `din_valid`.
- `dout_ready`=0 across two captures: the first sample is held, the second is dropped and `ovf`=1. A later `cfg_load` clears `ovf`.
- Capture coincides with the handshake: the new sample loads, `dout_valid` stays 1 and `ovf` stays 0.
- `cfg_enable` dropped mid-RUN, with `cfg_load` in the same cycle: the next state is IDLE, `busy`=0, `rate_q` is updated and all outputs are 0.
- Sparse `din_valid` (1 in 3 cycles) with R=4: strobes occur on every 4th valid only, and the phase counter does not advance on idle cycles.
